demux1to2_frame: RTL and testbench
==================================

# demux1to2_frame

Registered 1-to-2 demultiplexer and frame reassembler for the traffic-light datapath. It is the receive end of the 2-to-1 8-bit select path. It takes the shared 8-bit word stream `Y`, tagged by select `C` (0 = A-side pattern, 1 = B-side pattern), and rebuilds `A`/`B` pattern pairs. Each completed pair is presented as a frame on held output registers, together with a frame strobe, an error strobe and a frame count. It sits between the shared pattern bus and the per-direction lamp drivers.

## Interface
- `WIDTH`, default 8: data word width.
- `CNT_W`, default 4: width of the frame counter.
- `TIMEOUT`, default 16: consecutive idle cycles allowed in `WAIT_B` before the partial frame is aborted. Legal range 2..2^16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `Y` input WIDTH: shared data word.
- `C` input 1: word tag; 0 = A word, 1 = B word.
- `valid` input 1: `Y`/`C` qualify this cycle. `Y` and `C` are ignored while `valid` is low.
- `A` output WIDTH: last completed frame, A word; held between frames.
- `B` output WIDTH: last completed frame, B word; held between frames.
- `frame_valid` output 1: one-cycle pulse when `A`/`B` update.
- `seq_err` output 1: one-cycle pulse on a sequence violation or timeout.
- `frame_cnt` output CNT_W: completed-frame count; wraps modulo 2^CNT_W.

## Operation
- Reset (`rst`=1 at a rising edge):
  - `A`=0, `B`=0, `frame_valid`=0, `seq_err`=0, `frame_cnt`=0.
  - Internal shadow register = 0, idle counter = 0, state = `WAIT_A`.
  - Reset overrides all other inputs, including `valid`.
  - Reset mid-frame discards the shadow word and leaves no pulse.
- Frame order is fixed: an A word (`C`=0) followed by a B word (`C`=1).
- State `WAIT_A`:
  - `valid`&`!C`: shadow <= `Y`; idle counter <= 0; go to `WAIT_B`.
  - `valid`&`C`: B word without a preceding A word. Pulse `seq_err`, discard the word, stay in `WAIT_A`.
  - `!valid`: no change.
- State `WAIT_B`:
  - `valid`&`C`: `A` <= shadow; `B` <= `Y`; pulse `frame_valid`; `frame_cnt` <= `frame_cnt`+1; go to `WAIT_A`.
  - `valid`&`!C`: repeated A word. Pulse `seq_err`; shadow <= `Y` (the newest A word restarts the frame); idle counter <= 0; stay in `WAIT_B`.
  - `!valid` and idle counter = TIMEOUT-1: timeout. Pulse `seq_err`; discard shadow; idle counter <= 0; go to `WAIT_A`.
  - `!valid` otherwise: idle counter +1.
- A `valid` word arriving on the would-be timeout cycle is processed normally; it takes precedence over the timeout.
- `A`/`B` change only on frame completion or reset. Partial frames never reach the outputs.
- `frame_cnt` wraps from 2^CNT_W-1 to 0 with no flag.
- `frame_valid` and `seq_err` are never high in the same cycle.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: B word sampled at edge N. `A`, `B`, `frame_valid` and `frame_cnt` are updated and visible after edge N; `frame_valid` is high for exactly the cycle following edge N.
- `seq_err` is high for exactly the cycle following the offending edge.
- Back-to-back frames are supported at full rate: A, B, A, B on consecutive cycles gives one frame every 2 cycles.
- Timeout: after the A word is accepted at edge K, with `valid` low thereafter, `seq_err` fires after edge K+TIMEOUT.
- No backpressure: every `valid` word is consumed in its cycle.

## Test plan
- Reset then basic frame:
  - Stimulus: `rst` 2 cycles; then (`Y`=8'h21, `C`=0, `valid`=1), then (`Y`=8'h84, `C`=1, `valid`=1).
  - Response: one cycle later, `A`=8'h21, `B`=8'h84, `frame_valid` pulse of width 1, `frame_cnt`=1. `A`/`B` are held while `valid`=0 for 10 cycles.
- Out-of-order words:
  - Stimulus: B word 8'h0F first, then A words 8'h11 and 8'h22, then B word 8'h33.
  - Response: `seq_err` pulses on the B word and again on the second A word. The final frame shows `A`=8'h22, `B`=8'h33, and `frame_cnt` increments by 1.
- Timeout with TIMEOUT=16:
  - Stimulus: A word 8'h55, then 16 idle cycles, then B word 8'hAA.
  - Response: `seq_err` fires after the 16th idle edge; the B word then produces a second `seq_err`; `A`/`B` are unchanged and there is no `frame_valid`.
  - Boundary check: B word on the 16th idle cycle completes the frame with no `seq_err`.
- Wrap-around:
  - Stimulus: 17 back-to-back frames with CNT_W=4.
  - Response: `frame_cnt` reads 15 after frame 15, 0 after frame 16 and 1 after frame 17; `frame_valid` pulses every 2 cycles.
- Reset mid-frame:
  - Stimulus: A word 8'h77, then `rst` 1 cycle, then B word 8'h99.
  - Response: all outputs are 0 after reset; the B word gives `seq_err` and no frame.
- Ignore when idle:
  - Stimulus: toggle `Y`/`C` with `valid`=0 for 20 cycles.
  - Response: no pulses; all outputs constant.

Source files
------------

// File: rtl/demux1to2_frame.sv
// Receive end of the shared 8-bit pattern bus: splits the tagged word stream
// back into A/B pattern pairs and presents each completed pair as a held frame.
module demux1to2_frame #(
   parameter int WIDTH   = 8,
   parameter int CNT_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Y,
   input  logic             C,
   input  logic             valid,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             frame_valid,
   output logic             seq_err,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

   typedef enum logic {
      WAIT_A = 1'b0,
      WAIT_B = 1'b1
   } state_t;

   state_t            state_reg;
   logic [WIDTH-1:0]  shadow_reg;
   logic [IDLE_W-1:0] idle_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= WAIT_A;
         shadow_reg  <= '0;
         idle_reg    <= '0;
         A           <= '0;
         B           <= '0;
         frame_valid <= 1'b0;
         seq_err     <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         // Strobes are single-cycle: cleared unless re-asserted below.
         frame_valid <= 1'b0;
         seq_err     <= 1'b0;
         unique case (state_reg)
            WAIT_A: begin
               if (valid && !C) begin
                  shadow_reg <= Y;
                  idle_reg   <= '0;
                  state_reg  <= WAIT_B;
               end else if (valid && C) begin
                  seq_err <= 1'b1;
               end
            end
            WAIT_B: begin
               // A valid word always wins over a coincident timeout.
               if (valid && C) begin
                  A           <= shadow_reg;
                  B           <= Y;
                  frame_valid <= 1'b1;
                  frame_cnt   <= frame_cnt + 1'b1;
                  state_reg   <= WAIT_A;
               end else if (valid && !C) begin
                  seq_err    <= 1'b1;
                  shadow_reg <= Y;
                  idle_reg   <= '0;
               end else if (idle_reg == IDLE_LAST) begin
                  seq_err    <= 1'b1;
                  shadow_reg <= '0;
                  idle_reg   <= '0;
                  state_reg  <= WAIT_A;
               end else begin
                  idle_reg <= idle_reg + 1'b1;
               end
            end
            default: state_reg <= WAIT_A;
         endcase
      end
   end

endmodule

// File: tb/tb_demux1to2_frame.sv
// Directed bench for demux1to2_frame: hand-computed expectations checked with
// immediate assertions one clock step at a time.
module tb_demux1to2_frame;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] Y = '0;
   logic       C = 1'b0;
   logic       valid = 1'b0;
   logic [7:0] A, B;
   logic       frame_valid, seq_err;
   logic [3:0] frame_cnt;

   int checks = 0;
   int errors = 0;

   demux1to2_frame #(.WIDTH(8), .CNT_W(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .Y(Y), .C(C), .valid(valid),
      .A(A), .B(B), .frame_valid(frame_valid), .seq_err(seq_err),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic cyc(input logic r, input logic [7:0] y, input logic c, input logic v);
      @(negedge clk);
      rst = r; Y = y; C = c; valid = v;
      @(posedge clk);
      #1;
      $display("step rst=%0b Y=%02h C=%0b valid=%0b -> A=%02h B=%02h fv=%0b err=%0b cnt=%0d",
               r, y, c, v, A, B, frame_valid, seq_err, frame_cnt);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                          input logic efv, input logic ese, input logic [3:0] ecnt);
      chk({tag, ".A"}, A, ea);
      chk({tag, ".B"}, B, eb);
      chk({tag, ".fv"}, frame_valid, efv);
      chk({tag, ".err"}, seq_err, ese);
      chk({tag, ".cnt"}, frame_cnt, ecnt);
   endtask

   initial begin
      // Reset then basic frame
      cyc(1, 8'h00, 0, 0);
      cyc(1, 8'h00, 0, 0);
      chk_all("reset", 8'h00, 8'h00, 0, 0, 4'd0);
      cyc(0, 8'h21, 0, 1);
      chk_all("basic_a", 8'h00, 8'h00, 0, 0, 4'd0);
      cyc(0, 8'h84, 1, 1);
      chk_all("basic_frame", 8'h21, 8'h84, 1, 0, 4'd1);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 8'h00, 0, 0);
         chk_all("basic_hold", 8'h21, 8'h84, 0, 0, 4'd1);
      end

      // Out-of-order words
      cyc(0, 8'h0F, 1, 1);
      chk_all("ooo_b_first", 8'h21, 8'h84, 0, 1, 4'd1);
      cyc(0, 8'h11, 0, 1);
      chk_all("ooo_a1", 8'h21, 8'h84, 0, 0, 4'd1);
      cyc(0, 8'h22, 0, 1);
      chk_all("ooo_a2_repeat", 8'h21, 8'h84, 0, 1, 4'd1);
      cyc(0, 8'h33, 1, 1);
      chk_all("ooo_frame", 8'h22, 8'h33, 1, 0, 4'd2);

      // Timeout: A word then 16 idle cycles, then a stray B word
      cyc(0, 8'h55, 0, 1);
      chk_all("to_a", 8'h22, 8'h33, 0, 0, 4'd2);
      for (int i = 1; i <= 15; i++) begin
         cyc(0, 8'h00, 0, 0);
         chk("to_idle.err", seq_err, 1'b0);
      end
      cyc(0, 8'h00, 0, 0);
      chk_all("to_fire", 8'h22, 8'h33, 0, 1, 4'd2);
      cyc(0, 8'hAA, 1, 1);
      chk_all("to_stray_b", 8'h22, 8'h33, 0, 1, 4'd2);

      // Boundary: B word on the 16th idle cycle completes the frame
      cyc(0, 8'h5A, 0, 1);
      for (int i = 1; i <= 15; i++) begin
         cyc(0, 8'h00, 0, 0);
         chk("bnd_idle.err", seq_err, 1'b0);
      end
      cyc(0, 8'hA5, 1, 1);
      chk_all("bnd_frame", 8'h5A, 8'hA5, 1, 0, 4'd3);

      // Wrap-around: reset, then 17 back-to-back frames
      cyc(1, 8'h00, 0, 0);
      chk_all("wrap_reset", 8'h00, 8'h00, 0, 0, 4'd0);
      for (int i = 1; i <= 17; i++) begin
         cyc(0, 8'(i), 0, 1);
         chk("wrap_a.fv", frame_valid, 1'b0);
         cyc(0, 8'(i + 8'h80), 1, 1);
         chk_all("wrap_frame", 8'(i), 8'(i + 8'h80), 1, 0, 4'(i % 16));
      end

      // Reset mid-frame, with valid B word asserted during reset
      cyc(0, 8'h77, 0, 1);
      chk_all("mid_a", 8'h11, 8'h91, 0, 0, 4'd1);
      cyc(1, 8'h99, 1, 1);
      chk_all("mid_reset", 8'h00, 8'h00, 0, 0, 4'd0);
      cyc(0, 8'h99, 1, 1);
      chk_all("mid_b_after", 8'h00, 8'h00, 0, 1, 4'd0);

      // Ignore when idle: Y/C toggle with valid low
      for (int i = 0; i < 20; i++) begin
         cyc(0, 8'(i * 37), i[0], 0);
         chk_all("ignore", 8'h00, 8'h00, 0, 0, 4'd0);
      end
      cyc(0, 8'h3C, 0, 1);
      cyc(0, 8'hC3, 1, 1);
      chk_all("post_ignore_frame", 8'h3C, 8'hC3, 1, 0, 4'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
